// File: rtl/borg_arb_pkg.sv
// Shared types and constants for the Borg peripheral-port arbiter.
package borg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      GAP   = 2'd3
   } arb_state_t;

   // Borg io op encodings (active-low strobes with size)
   localparam logic [1:0] OP_IDLE = 2'b11;
   localparam logic [1:0] OP_BYTE = 2'b00;
   localparam logic [1:0] OP_HALF = 2'b01;
   localparam logic [1:0] OP_WORD = 2'b10;

   // A requester is asking for service when either strobe is not idle
   function automatic logic req_valid(input logic [1:0] write_n, input logic [1:0] read_n);
      return (write_n != OP_IDLE) || (read_n != OP_IDLE);
   endfunction

endpackage

// File: rtl/borg_arb_rr_pick.sv
// Two-way round-robin picker: on contention grants the requester not served last.
module borg_arb_rr_pick
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] gnt
);

   // Pick the single requester, or alternate away from 'last' when both ask
   always_comb begin
      gnt = 2'b00;
      case (valid)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/borg_access_arbiter.sv
// Shares the Borg 6-bit register port between the CPU bus slice (req0) and the
// command sequencer (req1). One access in flight, round-robin on contention.
// Optional: BORG_ARB_TIMEOUT_EN adds an ISSUE watchdog that forces completion
// with TIMEOUT_DATA and sets the sticky err_timeout flag.
//
//  state | meaning
//  IDLE  | arbitrate, latch winner's request
//  ISSUE | drive Borg io_* from latches, wait for io_data_ready
//  RESP  | one-cycle ready pulse to owner, io ops idle
//  GAP   | one dead cycle so the owner can drop its request
module borg_access_arbiter
   import borg_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic [1:0]  req0_write_n,
   input  logic [1:0]  req0_read_n,
   output logic [31:0] req0_rdata,
   output logic        req0_ready,
   input  logic [5:0]  req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic [1:0]  req1_write_n,
   input  logic [1:0]  req1_read_n,
   output logic [31:0] req1_rdata,
   output logic        req1_ready,
   output logic [5:0]  io_address,
   output logic [31:0] io_data_in,
   output logic [1:0]  io_data_write_n,
   output logic [1:0]  io_data_read_n,
   input  logic [31:0] io_data_out,
   input  logic        io_data_ready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        err_timeout,
   input  logic        err_clr
);

   arb_state_t  state;
   logic        last;
   logic        owner;
   logic [1:0]  valid;
   logic [1:0]  pick_gnt;
   logic [1:0]  sel_write_n;
   logic [1:0]  sel_read_n;
   logic        done;
   logic        to_hit;
   logic [31:0] resp_data;

`ifdef BORG_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] to_cnt;
`endif

   assign valid[0] = req_valid(req0_write_n, req0_read_n);
   assign valid[1] = req_valid(req1_write_n, req1_read_n);

   borg_arb_rr_pick u_pick (
      .valid (valid),
      .last  (last),
      .gnt   (pick_gnt)
   );

   // Write wins when a requester strobes both; its read is dropped
   assign sel_write_n = pick_gnt[1] ? req1_write_n : req0_write_n;
   assign sel_read_n  = (sel_write_n != OP_IDLE) ? OP_IDLE :
                        (pick_gnt[1] ? req1_read_n : req0_read_n);

   assign busy = (state != IDLE);

   // Completion decode for the ISSUE state: Borg ready, or watchdog expiry
   always_comb begin
      done      = 1'b0;
      to_hit    = 1'b0;
      resp_data = '0;
      if (state == ISSUE) begin
         if (io_data_ready) begin
            done      = 1'b1;
            resp_data = (io_data_read_n != OP_IDLE) ? io_data_out : 32'h0;
         end
`ifdef BORG_ARB_TIMEOUT_EN
         else if (to_cnt == TO_LAST) begin
            done      = 1'b1;
            to_hit    = 1'b1;
            resp_data = (io_data_read_n != OP_IDLE) ? TIMEOUT_DATA : 32'h0;
         end
`endif
      end
   end

   // Arbiter FSM with registered Borg-side and requester-side outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         last            <= 1'b1;
         owner           <= 1'b0;
         grant           <= 2'b00;
         io_address      <= '0;
         io_data_in      <= '0;
         io_data_write_n <= OP_IDLE;
         io_data_read_n  <= OP_IDLE;
         req0_ready      <= 1'b0;
         req1_ready      <= 1'b0;
         req0_rdata      <= '0;
         req1_rdata      <= '0;
`ifdef BORG_ARB_TIMEOUT_EN
         to_cnt          <= '0;
`endif
      end else begin
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_gnt != 2'b00) begin
                  owner           <= pick_gnt[1];
                  last            <= pick_gnt[1];
                  grant           <= pick_gnt;
                  io_address      <= pick_gnt[1] ? req1_addr  : req0_addr;
                  io_data_in      <= pick_gnt[1] ? req1_wdata : req0_wdata;
                  io_data_write_n <= sel_write_n;
                  io_data_read_n  <= sel_read_n;
`ifdef BORG_ARB_TIMEOUT_EN
                  to_cnt          <= '0;
`endif
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (done) begin
                  io_data_write_n <= OP_IDLE;
                  io_data_read_n  <= OP_IDLE;
                  if (owner) begin
                     req1_rdata <= resp_data;
                     req1_ready <= 1'b1;
                  end else begin
                     req0_rdata <= resp_data;
                     req0_ready <= 1'b1;
                  end
                  state <= RESP;
               end
`ifdef BORG_ARB_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + CW'(1);
               end
`endif
            end
            RESP: begin
               grant <= 2'b00;
               state <= GAP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BORG_ARB_TIMEOUT_EN
   // Sticky timeout flag; a new timeout beats a simultaneous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         err_timeout <= 1'b0;
      else if (to_hit)
         err_timeout <= 1'b1;
      else if (err_clr)
         err_timeout <= 1'b0;
   end
`else
   logic unused_cfg;
   assign unused_cfg  = ^{err_clr, to_hit, TIMEOUT_DATA, TIMEOUT_CYCLES};
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_borg_access_arbiter.sv
// Directed bench for borg_access_arbiter with a simple Borg responder model.
module tb_borg_access_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  req0_addr = '0, req1_addr = '0;
   logic [31:0] req0_wdata = '0, req1_wdata = '0;
   logic [1:0]  req0_write_n = 2'b11, req0_read_n = 2'b11;
   logic [1:0]  req1_write_n = 2'b11, req1_read_n = 2'b11;
   logic [31:0] req0_rdata, req1_rdata;
   logic        req0_ready, req1_ready;
   logic [5:0]  io_address;
   logic [31:0] io_data_in;
   logic [1:0]  io_data_write_n, io_data_read_n;
   logic [31:0] io_data_out;
   logic        io_data_ready;
   logic [1:0]  grant;
   logic        busy;
   logic        err_timeout;
   logic        err_clr = 1'b0;

   logic        borg_zero_wait = 1'b1;
   logic [31:0] borg_rdata = 32'h1234_5678;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   // Borg model: answers in the same cycle an op is presented
   assign io_data_out   = borg_rdata;
   assign io_data_ready = borg_zero_wait &&
                          ((io_data_write_n != 2'b11) || (io_data_read_n != 2'b11));

   borg_access_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
      .clock           (clock),
      .reset           (reset),
      .req0_addr       (req0_addr),
      .req0_wdata      (req0_wdata),
      .req0_write_n    (req0_write_n),
      .req0_read_n     (req0_read_n),
      .req0_rdata      (req0_rdata),
      .req0_ready      (req0_ready),
      .req1_addr       (req1_addr),
      .req1_wdata      (req1_wdata),
      .req1_write_n    (req1_write_n),
      .req1_read_n     (req1_read_n),
      .req1_rdata      (req1_rdata),
      .req1_ready      (req1_ready),
      .io_address      (io_address),
      .io_data_in      (io_data_in),
      .io_data_write_n (io_data_write_n),
      .io_data_read_n  (io_data_read_n),
      .io_data_out     (io_data_out),
      .io_data_ready   (io_data_ready),
      .grant           (grant),
      .busy            (busy),
      .err_timeout     (err_timeout),
      .err_clr         (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_reqs();
      req0_write_n = 2'b11; req0_read_n = 2'b11;
      req1_write_n = 2'b11; req1_read_n = 2'b11;
   endtask

   logic [1:0] exp_g [4];
   int         ng, nr;
   logic       saw_ready;

   initial begin
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

      // reset state
      step(); step();
      chk("rst_wr_n",  {30'd0, io_data_write_n}, 32'h3);
      chk("rst_rd_n",  {30'd0, io_data_read_n},  32'h3);
      chk("rst_addr",  {26'd0, io_address},      32'h0);
      chk("rst_grant", {30'd0, grant},           32'h0);
      chk("rst_busy",  {31'd0, busy},            32'h0);
      chk("rst_rdy",   {30'd0, req1_ready, req0_ready}, 32'h0);
      chk("rst_rdata0", req0_rdata, 32'h0);
      chk("rst_err",   {31'd0, err_timeout},     32'h0);
      reset = 1'b0;
      step();

      // req0 read, zero-wait Borg
      req0_addr = 6'h04; req0_read_n = 2'b10;
      step();
      idle_reqs();
      chk("t1_rd_n",   {30'd0, io_data_read_n}, 32'h2);
      chk("t1_wr_n",   {30'd0, io_data_write_n}, 32'h3);
      chk("t1_addr",   {26'd0, io_address}, 32'h04);
      chk("t1_grant",  {30'd0, grant}, 32'h1);
      chk("t1_rdy_n1", {31'd0, req0_ready}, 32'h0);
      step();
      chk("t1_rdy",    {30'd0, req1_ready, req0_ready}, 32'h1);
      chk("t1_rdata",  req0_rdata, 32'h1234_5678);
      chk("t1_rd_off", {30'd0, io_data_read_n}, 32'h3);
      step();
      chk("t1_rdy_1cy", {31'd0, req0_ready}, 32'h0);
      chk("t1_gap_gnt", {30'd0, grant}, 32'h0);
      chk("t1_gap_busy", {31'd0, busy}, 32'h1);
      step();
      chk("t1_idle",   {31'd0, busy}, 32'h0);

      // req1 byte write
      req1_addr = 6'h3F; req1_wdata = 32'h0000_00A5; req1_write_n = 2'b00;
      step();
      idle_reqs();
      chk("t2_addr",   {26'd0, io_address}, 32'h3F);
      chk("t2_wdata",  io_data_in, 32'hA5);
      chk("t2_wr_n",   {30'd0, io_data_write_n}, 32'h0);
      chk("t2_rd_n",   {30'd0, io_data_read_n}, 32'h3);
      chk("t2_grant",  {30'd0, grant}, 32'h2);
      step();
      chk("t2_rdy",    {30'd0, req1_ready, req0_ready}, 32'h2);
      chk("t2_rdata1", req1_rdata, 32'h0);
      chk("t2_rdata0_held", req0_rdata, 32'h1234_5678);
      chk("t2_wr_off", {30'd0, io_data_write_n}, 32'h3);
      step(); step();

      // stalled Borg: ISSUE holds without completing
      borg_zero_wait = 1'b0; borg_rdata = 32'hCAFE_0001;
      req0_addr = 6'h10; req0_read_n = 2'b01;
      step();
      idle_reqs();
      saw_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (req0_ready || req1_ready) saw_ready = 1'b1;
      end
`ifdef BORG_ARB_TIMEOUT_EN
      // 8th ISSUE cycle is now showing; completion is forced at the next edge
      chk("to_no_early", {31'd0, saw_ready}, 32'h0);
      chk("to_still_rd", {30'd0, io_data_read_n}, 32'h1);
      step();
      chk("to_rdy",   {31'd0, req0_ready}, 32'h1);
      chk("to_rdata", req0_rdata, 32'hDEAD_BEEF);
      chk("to_err",   {31'd0, err_timeout}, 32'h1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("to_clr",   {31'd0, err_timeout}, 32'h0);
      step(); step();
      borg_zero_wait = 1'b1;
`else
      for (int i = 0; i < 13; i++) begin
         step();
         if (req0_ready || req1_ready) saw_ready = 1'b1;
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("wait_no_rdy", {31'd0, saw_ready}, 32'h0);
      chk("wait_busy",   {31'd0, busy}, 32'h1);
      chk("wait_rd_n",   {30'd0, io_data_read_n}, 32'h1);
      chk("wait_grant",  {30'd0, grant}, 32'h1);
      chk("wait_err",    {31'd0, err_timeout}, 32'h0);
      borg_zero_wait = 1'b1;
      step();
      chk("wait_rdy",   {31'd0, req0_ready}, 32'h1);
      chk("wait_rdata", req0_rdata, 32'hCAFE_0001);
      step(); step();
`endif

      // both requesters held from reset: alternating grants
      reset = 1'b1;
      borg_rdata = 32'h5555_AAAA;
      req0_addr = 6'h01; req0_read_n = 2'b10;
      req1_addr = 6'h02; req1_wdata = 32'h77; req1_write_n = 2'b10;
      step();
      reset = 1'b0;
      ng = 0; nr = 0;
      for (int c = 0; c < 40 && nr < 4; c++) begin
         step();
         if ((io_data_write_n != 2'b11 || io_data_read_n != 2'b11) && ng < 4) begin
            chk($sformatf("rr_grant%0d", ng), {30'd0, grant}, {30'd0, exp_g[ng]});
            ng++;
         end
         if ((req0_ready || req1_ready) && nr < 4) begin
            chk($sformatf("rr_ready%0d", nr), {30'd0, req1_ready, req0_ready}, {30'd0, exp_g[nr]});
            nr++;
         end
      end
      chk("rr_n_grants", ng, 4);
      chk("rr_n_ready",  nr, 4);
      idle_reqs();
      chk("rr_rdata0", req0_rdata, 32'h5555_AAAA);
      chk("rr_rdata1", req1_rdata, 32'h0);
      step(); step(); step();

      // reset asserted mid-ISSUE
      borg_zero_wait = 1'b0;
      req0_addr = 6'h08; req0_read_n = 2'b10;
      step();
      idle_reqs();
      chk("mr_in_issue", {30'd0, io_data_read_n}, 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("mr_rd_n",  {30'd0, io_data_read_n}, 32'h3);
      chk("mr_busy",  {31'd0, busy}, 32'h0);
      chk("mr_grant", {30'd0, grant}, 32'h0);
      borg_zero_wait = 1'b1;
      step();
      reset = 1'b0;
      saw_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (req0_ready || req1_ready || busy) saw_ready = 1'b1;
      end
      chk("mr_no_replay", {31'd0, saw_ready}, 32'h0);
      chk("mr_rdata0", req0_rdata, 32'h0);

      // write and read strobed together: write only
      req0_addr = 6'h20; req0_wdata = 32'h0BAD_F00D;
      req0_write_n = 2'b10; req0_read_n = 2'b10;
      step();
      idle_reqs();
      chk("wr_rd_wr_n", {30'd0, io_data_write_n}, 32'h2);
      chk("wr_rd_rd_n", {30'd0, io_data_read_n},  32'h3);
      chk("wr_rd_data", io_data_in, 32'h0BAD_F00D);
      step();
      chk("wr_rd_rdy",  {30'd0, req1_ready, req0_ready}, 32'h1);
      chk("wr_rd_rdata", req0_rdata, 32'h0);
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
